// File: rtl/mips.sv
// Multicycle 32-bit MIPS subset core with a 16-bit asynchronous SRAM port.
// Every instruction and data word moves as two big-endian halfword accesses, one cycle each.
module mips (
  input  logic        clock,
  input  logic        reset,
  output logic [17:0] addr,
  inout  wire  [15:0] data,
  output logic        wre,
  output logic        oute,
  output logic        hb_mask,
  output logic        lb_mask,
  output logic        chip_en
);

  typedef enum logic [2:0] {
    FETCH_HI  = 3'd0,
    FETCH_LO  = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM_HI    = 3'd4,
    MEM_LO    = 3'd5,
    WRITEBACK = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  state_e      state_q, state_d;
  logic        go_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  logic        drive;
  logic [15:0] wdata;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] r_res;
  logic        fn_ok;

  logic        unused_shamt;

  assign op = ir_q[31:26];
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign rd = ir_q[15:11];
  assign fn = ir_q[5:0];
  assign unused_shamt = ^ir_q[10:6];

  // The core only drives the bus during a write cycle; reset clears go_q and releases it at once.
  assign data = drive ? wdata : 16'bz;

  always_comb begin
    r_res = '0;
    fn_ok = 1'b1;
    case (fn)
      FN_ADD:  r_res = a_q + b_q;
      FN_SUB:  r_res = a_q - b_q;
      FN_AND:  r_res = a_q & b_q;
      FN_OR:   r_res = a_q | b_q;
      FN_SLT:  r_res = {31'b0, $signed(a_q) < $signed(b_q)};
      default: fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    rf_we   = 1'b0;
    rf_wa   = rd;
    rf_wd   = alu_q;
    addr    = '0;
    wre     = 1'b1;
    oute    = 1'b1;
    chip_en = 1'b1;
    hb_mask = 1'b1;
    lb_mask = 1'b1;
    drive   = 1'b0;
    wdata   = '0;

    // go_q holds the core idle until the first rising edge after reset release.
    if (go_q) begin
      case (state_q)
        FETCH_HI: begin
          addr          = {pc_q[18:2], 1'b0};
          chip_en       = 1'b0;
          hb_mask       = 1'b0;
          lb_mask       = 1'b0;
          oute          = 1'b0;
          ir_d[31:16]   = data;
          state_d       = FETCH_LO;
        end
        FETCH_LO: begin
          addr          = {pc_q[18:2], 1'b1};
          chip_en       = 1'b0;
          hb_mask       = 1'b0;
          lb_mask       = 1'b0;
          oute          = 1'b0;
          ir_d[15:0]    = data;
          pc_d          = pc_q + 32'd4;
          state_d       = DECODE;
        end
        DECODE: begin
          a_d     = rf_q[rs];
          b_d     = rf_q[rt];
          imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
          state_d = EXECUTE;
        end
        EXECUTE: begin
          state_d = FETCH_HI;
          case (op)
            OP_BEQ: begin
              if (a_q == b_q) pc_d = pc_q + {imm_q[29:0], 2'b00};
            end
            OP_J:     pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            OP_RTYPE: begin
              if (fn_ok) begin
                alu_d   = r_res;
                state_d = WRITEBACK;
              end
            end
            OP_ADDI: begin
              alu_d   = a_q + imm_q;
              state_d = WRITEBACK;
            end
            OP_LW, OP_SW: begin
              alu_d   = a_q + imm_q;
              state_d = MEM_HI;
            end
            default: state_d = FETCH_HI;
          endcase
        end
        MEM_HI, MEM_LO: begin
          addr    = {alu_q[18:2], state_q == MEM_LO};
          chip_en = 1'b0;
          hb_mask = 1'b0;
          lb_mask = 1'b0;
          if (op == OP_SW) begin
            wre   = 1'b0;
            drive = 1'b1;
            wdata = (state_q == MEM_HI) ? b_q[31:16] : b_q[15:0];
          end else begin
            oute = 1'b0;
            if (state_q == MEM_HI) mdr_d[31:16] = data;
            else                   mdr_d[15:0]  = data;
          end
          if (state_q == MEM_HI)   state_d = MEM_LO;
          else if (op == OP_SW)    state_d = FETCH_HI;
          else                     state_d = WRITEBACK;
        end
        WRITEBACK: begin
          rf_we   = 1'b1;
          state_d = FETCH_HI;
          case (op)
            OP_RTYPE: rf_wa = rd;
            OP_ADDI:  rf_wa = rt;
            OP_LW: begin
              rf_wa = rt;
              rf_wd = mdr_q;
            end
            default:  rf_we = 1'b0;
          endcase
        end
        default: state_d = FETCH_HI;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_HI;
      go_q    <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= 1'b1;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end

  // Register 0 is never written, so it always reads as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && rf_wa != 5'd0) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_mips.sv
// Bench for the mips core: SRAM model, instruction-level reference model that predicts
// the bus activity of every cycle, plus hand-computed result checks.
`timescale 1ns/1ps
module tb_mips;

  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_WR   = 2'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] addr;
  wire  [15:0] data;
  logic        wre, oute, hb_mask, lb_mask, chip_en;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] sram [0:262143];
  logic [33:0] wr_log [$];

  logic [31:0] mw [0:131071];
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;
  logic [35:0] exp_q [$];

  always #5 clock = ~clock;

  pullup (data);

  assign data = (!chip_en && !oute && wre) ? sram[addr] : 16'hzzzz;

  mips dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .data    (data),
    .wre     (wre),
    .oute    (oute),
    .hb_mask (hb_mask),
    .lb_mask (lb_mask),
    .chip_en (chip_en)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the middle of the next cycle and commit any SRAM write in progress.
  task automatic tick();
    @(negedge clock);
    if (!chip_en && !wre) begin
      if (!hb_mask) sram[addr][15:8] = data[15:8];
      if (!lb_mask) sram[addr][7:0]  = data[7:0];
      wr_log.push_back({addr, data});
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [17:0] hw(input logic [31:0] a, input logic lo);
    return {a[18:2], lo};
  endfunction

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {sram[hw(a, 1'b0)], sram[hw(a, 1'b1)]};
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    sram[hw(a, 1'b0)] = w[31:16];
    sram[hw(a, 1'b1)] = w[15:0];
    mw[a[18:2]]       = w;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 262144; i++) sram[i] = '0;
    for (int i = 0; i < 131072; i++) mw[i] = '0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0;
    exp_q.delete();
    wr_log.delete();
  endtask

  function automatic logic [35:0] bus(input logic [1:0] k, input logic [17:0] a, input logic [15:0] d);
    return {k, a, d};
  endfunction

  // One instruction at the architectural level, emitting its bus cycles in order.
  task automatic model_step();
    logic [31:0] ins, a, b, simm, res, ea, nxt;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic        ok;
    ins  = mw[m_pc[18:2]];
    op   = ins[31:26];
    rs   = ins[25:21];
    rt   = ins[20:16];
    rd   = ins[15:11];
    fn   = ins[5:0];
    simm = {{16{ins[15]}}, ins[15:0]};
    a    = m_reg[rs];
    b    = m_reg[rt];
    nxt  = m_pc + 32'd4;
    exp_q.push_back(bus(K_RD, hw(m_pc, 1'b0), 16'h0));
    exp_q.push_back(bus(K_RD, hw(m_pc, 1'b1), 16'h0));
    exp_q.push_back(bus(K_IDLE, 18'h0, 16'h0));
    exp_q.push_back(bus(K_IDLE, 18'h0, 16'h0));
    case (op)
      6'h00: begin
        ok  = 1'b1;
        res = '0;
        case (fn)
          6'h20:   res = a + b;
          6'h22:   res = a - b;
          6'h24:   res = a & b;
          6'h25:   res = a | b;
          6'h2a:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          exp_q.push_back(bus(K_IDLE, 18'h0, 16'h0));
          if (rd != 0) m_reg[rd] = res;
        end
      end
      6'h08: begin
        exp_q.push_back(bus(K_IDLE, 18'h0, 16'h0));
        if (rt != 0) m_reg[rt] = a + simm;
      end
      6'h23: begin
        ea = a + simm;
        exp_q.push_back(bus(K_RD, hw(ea, 1'b0), 16'h0));
        exp_q.push_back(bus(K_RD, hw(ea, 1'b1), 16'h0));
        exp_q.push_back(bus(K_IDLE, 18'h0, 16'h0));
        if (rt != 0) m_reg[rt] = mw[ea[18:2]];
      end
      6'h2b: begin
        ea = a + simm;
        exp_q.push_back(bus(K_WR, hw(ea, 1'b0), b[31:16]));
        exp_q.push_back(bus(K_WR, hw(ea, 1'b1), b[15:0]));
        mw[ea[18:2]] = b;
      end
      6'h04: if (a == b) nxt = nxt + (simm << 2);
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic gen_trace(input int n);
    while (exp_q.size() < n) model_step();
  endtask

  // Compare the DUT bus against the predicted trace, one entry per cycle.
  task automatic run_trace(input string tag);
    logic [35:0] e;
    logic [4:0]  ctl_exp;
    logic [38:0] act, expv;
    int c;
    c = 0;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      case (e[35:34])
        K_RD:    ctl_exp = 5'b10000;
        K_WR:    ctl_exp = 5'b01000;
        default: ctl_exp = 5'b11111;
      endcase
      act  = {wre, oute, chip_en, hb_mask, lb_mask,
              (e[35:34] != K_IDLE) ? addr : 18'h0,
              (e[35:34] == K_WR) ? data : 16'h0};
      expv = {ctl_exp, e[33:16], e[15:0]};
      check($sformatf("%s_bus[%0d]", tag, c), 64'(act), 64'(expv));
      c++;
    end
  endtask

  initial begin
    logic found;

    // ---------------- Phase A: ALU, memory, branch and jump program ----------------
    reset = 1'b0;
    clear_all();
    put_word(32'h00, i_ins(6'h08, 5'd0, 5'd1, 16'd5));          // addi $1,$0,5
    put_word(32'h04, i_ins(6'h08, 5'd0, 5'd2, 16'hFFFD));       // addi $2,$0,-3
    put_word(32'h08, r_ins(5'd1, 5'd2, 5'd3, 6'h20));           // add  $3,$1,$2
    put_word(32'h0C, r_ins(5'd1, 5'd2, 5'd4, 6'h22));           // sub  $4,$1,$2
    put_word(32'h10, r_ins(5'd2, 5'd1, 5'd5, 6'h2a));           // slt  $5,$2,$1
    put_word(32'h14, i_ins(6'h08, 5'd0, 5'd0, 16'd7));          // addi $0,$0,7
    put_word(32'h18, r_ins(5'd0, 5'd0, 5'd7, 6'h20));           // add  $7,$0,$0
    put_word(32'h1C, i_ins(6'h2b, 5'd0, 5'd3, 16'h0008));       // sw   $3,8($0)
    put_word(32'h20, i_ins(6'h23, 5'd0, 5'd6, 16'h0008));       // lw   $6,8($0)
    put_word(32'h24, i_ins(6'h2b, 5'd0, 5'd4, 16'h0100));
    put_word(32'h28, i_ins(6'h2b, 5'd0, 5'd5, 16'h0104));
    put_word(32'h2C, i_ins(6'h2b, 5'd0, 5'd6, 16'h0108));
    put_word(32'h30, i_ins(6'h2b, 5'd0, 5'd7, 16'h010C));
    put_word(32'h34, r_ins(5'd1, 5'd2, 5'd8, 6'h24));           // and  $8,$1,$2
    put_word(32'h38, r_ins(5'd1, 5'd2, 5'd9, 6'h25));           // or   $9,$1,$2
    put_word(32'h3C, i_ins(6'h2b, 5'd0, 5'd8, 16'h0110));
    put_word(32'h40, i_ins(6'h2b, 5'd0, 5'd9, 16'h0114));
    put_word(32'h44, 32'hFC00_0000);                            // unsupported -> NOP
    put_word(32'h48, i_ins(6'h04, 5'd1, 5'd2, 16'd5));          // beq not taken
    put_word(32'h4C, i_ins(6'h04, 5'd1, 5'd1, 16'd1));          // beq taken, skip 0x50
    put_word(32'h50, i_ins(6'h2b, 5'd0, 5'd1, 16'h0118));       // skipped store
    put_word(32'h54, {6'h02, 26'h0});                           // j 0
    put_word(32'h10C, 32'hDEAD_BEEF);
    put_word(32'h118, 32'hCAFE_F00D);
    gen_trace(250);

    repeat (3) tick();
    check("reset_ctl",  64'({wre, oute, chip_en, hb_mask, lb_mask}), 64'h1F);
    check("reset_addr", 64'(addr), 64'h0);
    check("reset_data", 64'(data), 64'hFFFF);

    reset = 1'b1;
    run_trace("progA");

    check("wr_count_ge2", 64'(wr_log.size() >= 2), 64'h1);
    if (wr_log.size() >= 2) begin
      check("sw_hi_cycle", 64'(wr_log[0]), 64'({18'h00004, 16'h0000}));
      check("sw_lo_cycle", 64'(wr_log[1]), 64'({18'h00005, 16'h0002}));
    end
    check("mem_08_add",  64'(sram_word(32'h08)),  64'h0000_0002);
    check("mem_100_sub", 64'(sram_word(32'h100)), 64'h0000_0008);
    check("mem_104_slt", 64'(sram_word(32'h104)), 64'h0000_0001);
    check("mem_108_lw",  64'(sram_word(32'h108)), 64'h0000_0002);
    check("mem_10c_r0",  64'(sram_word(32'h10C)), 64'h0000_0000);
    check("mem_110_and", 64'(sram_word(32'h110)), 64'h0000_0005);
    check("mem_114_or",  64'(sram_word(32'h114)), 64'hFFFF_FFFD);
    check("mem_118_skip", 64'(sram_word(32'h118)), 64'hCAFE_F00D);

    // ---------------- Phase B: store then a self loop ----------------
    reset = 1'b0;
    clear_all();
    put_word(32'h00, i_ins(6'h08, 5'd0, 5'd1, 16'h1234));      // addi $1,$0,0x1234
    put_word(32'h04, i_ins(6'h2b, 5'd0, 5'd1, 16'h0200));      // sw   $1,0x200($0)
    put_word(32'h08, i_ins(6'h04, 5'd1, 5'd1, 16'hFFFF));      // beq  $1,$1,-1
    gen_trace(60);
    repeat (2) tick();
    reset = 1'b1;
    run_trace("progB");
    check("mem_200", 64'(sram_word(32'h200)), 64'h0000_1234);

    // ---------------- Phase C: release sequence and reset during a write ----------------
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("rel_c1", 64'({wre, oute, chip_en, hb_mask, lb_mask, addr}), 64'({5'b10000, 18'h00000}));
    tick();
    check("rel_c2", 64'({wre, oute, chip_en, hb_mask, lb_mask, addr}), 64'({5'b10000, 18'h00001}));
    tick();
    check("rel_c3_ctl", 64'({wre, oute, chip_en, hb_mask, lb_mask}), 64'h1F);

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (!wre) found = 1'b1;
    end
    check("write_seen", 64'(found), 64'h1);
    if (found) begin
      check("abort_pre", 64'({addr, data}), 64'({18'h00100, 16'h0000}));
      reset = 1'b0;
      #1;
      check("abort_ctl",  64'({wre, oute, chip_en, hb_mask, lb_mask}), 64'h1F);
      check("abort_addr", 64'(addr), 64'h0);
      check("abort_data", 64'(data), 64'hFFFF);
      repeat (2) tick();
      check("abort_hold", 64'({wre, oute, chip_en, hb_mask, lb_mask}), 64'h1F);
      reset = 1'b1;
      tick();
      check("restart", 64'({wre, oute, chip_en, hb_mask, lb_mask, addr}), 64'({5'b10000, 18'h00000}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
